// File: rtl/issue_ctrl.sv
// Dual-issue in-order issue control: picks 0/1/2 instructions from the buffer head,
// tracks one outstanding load for load-use bubbles, and registers the EX-stage lanes.
module issue_ctrl #(
  parameter int INFO_W = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        in_valid,
  input  logic [4:0]        a_rs1,
  input  logic [4:0]        a_rs2,
  input  logic [4:0]        b_rs1,
  input  logic [4:0]        b_rs2,
  input  logic [4:0]        a_rd,
  input  logic [4:0]        b_rd,
  input  logic              a_we,
  input  logic              b_we,
  input  logic              a_is_load,
  input  logic              b_is_load,
  input  logic              a_is_mem,
  input  logic              b_is_mem,
  input  logic              a_is_br,
  input  logic              b_is_br,
  input  logic              a_is_solo,
  input  logic              b_is_solo,
  input  logic [INFO_W-1:0] a_info,
  input  logic [INFO_W-1:0] b_info,
  input  logic              flush_BR,
  input  logic              stall,
  output logic [1:0]        using_num,
  output logic [1:0]        ex_valid,
  output logic [INFO_W-1:0] ex_info_a,
  output logic [INFO_W-1:0] ex_info_b,
  output logic [31:0]       dual_cnt,
  output logic [31:0]       stall_cnt
);

  logic              ld_pend_q, ld_pend_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [1:0]        ex_valid_q;
  logic [INFO_W-1:0] ex_info_a_q, ex_info_b_q;
  logic [31:0]       dual_cnt_q, stall_cnt_q;

  logic haz_a, haz_b, pair_conf, issue_a, issue_b, a_ld, b_ld;

  // A branch in lane B is allowed to pair, so its flag has no effect here.
  logic unused_b_is_br;
  assign unused_b_is_br = b_is_br;

  assign haz_a = ld_pend_q && (((a_rs1 != 5'd0) && (a_rs1 == ld_rd_q)) ||
                               ((a_rs2 != 5'd0) && (a_rs2 == ld_rd_q)));
  assign haz_b = ld_pend_q && (((b_rs1 != 5'd0) && (b_rs1 == ld_rd_q)) ||
                               ((b_rs2 != 5'd0) && (b_rs2 == ld_rd_q)));

  assign pair_conf = (a_we && (a_rd != 5'd0) && ((a_rd == b_rs1) || (a_rd == b_rs2))) ||
                     (a_is_mem && b_is_mem) || a_is_br || a_is_solo || b_is_solo;

  // Reset gates issue so nothing is consumed from the buffer while rstn is low.
  assign issue_a   = rstn && in_valid[1] && !stall && !flush_BR && !haz_a;
  assign issue_b   = issue_a && in_valid[0] && !haz_b && !pair_conf;
  assign using_num = {issue_a && issue_b, issue_a ^ issue_b};

  assign a_ld = issue_a && a_is_load && a_we && (a_rd != 5'd0);
  assign b_ld = issue_b && b_is_load && b_we && (b_rd != 5'd0);

  always_comb begin
    ld_pend_d = a_ld || b_ld;
    ld_rd_d   = 5'd0;
    if (b_ld)      ld_rd_d = b_rd;
    else if (a_ld) ld_rd_d = a_rd;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_pend_q   <= 1'b0;
      ld_rd_q     <= 5'd0;
      ex_valid_q  <= 2'b00;
      ex_info_a_q <= '0;
      ex_info_b_q <= '0;
      dual_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else if (flush_BR) begin
      ld_pend_q  <= 1'b0;
      ex_valid_q <= 2'b00;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      ld_pend_q  <= ld_pend_d;
      ld_rd_q    <= ld_rd_d;
      ex_valid_q <= {issue_a, issue_b};
      if (issue_a) ex_info_a_q <= a_info;
      if (issue_b) ex_info_b_q <= b_info;
      if (using_num == 2'd2) dual_cnt_q <= dual_cnt_q + 32'd1;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_info_a = ex_info_a_q;
  assign ex_info_b = ex_info_b_q;
  assign dual_cnt  = dual_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: directed issue scenarios followed by a random
// run checked against an independent behavioural model of issue and EX state.
module tb_issue_ctrl;
  localparam int INFO_W = 256;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        in_valid;
  logic [4:0]        a_rs1, a_rs2, b_rs1, b_rs2, a_rd, b_rd;
  logic              a_we, b_we, a_is_load, b_is_load, a_is_mem, b_is_mem;
  logic              a_is_br, b_is_br, a_is_solo, b_is_solo;
  logic [INFO_W-1:0] a_info, b_info;
  logic              flush_BR, stall;
  logic [1:0]        using_num, ex_valid;
  logic [INFO_W-1:0] ex_info_a, ex_info_b;
  logic [31:0]       dual_cnt, stall_cnt;

  issue_ctrl #(.INFO_W(INFO_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .b_rs1(b_rs1), .b_rs2(b_rs2),
    .a_rd(a_rd), .b_rd(b_rd), .a_we(a_we), .b_we(b_we),
    .a_is_load(a_is_load), .b_is_load(b_is_load), .a_is_mem(a_is_mem), .b_is_mem(b_is_mem),
    .a_is_br(a_is_br), .b_is_br(b_is_br), .a_is_solo(a_is_solo), .b_is_solo(b_is_solo),
    .a_info(a_info), .b_info(b_info), .flush_BR(flush_BR), .stall(stall),
    .using_num(using_num), .ex_valid(ex_valid), .ex_info_a(ex_info_a), .ex_info_b(ex_info_b),
    .dual_cnt(dual_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        v;
    logic [INFO_W-1:0] ia, ib;
    logic              chk_a, chk_b;
    logic [31:0]       dual, stl;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state
  logic [1:0]        m_v = 2'b00;
  logic [INFO_W-1:0] m_ia = '0, m_ib = '0;
  logic              m_ld = 1'b0;
  logic [4:0]        m_ldrd = 5'd0;
  logic [31:0]       m_dual = 32'd0, m_stall = 32'd0;

  task automatic chk(input string tag, input logic [INFO_W-1:0] obs, input logic [INFO_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int rs1, input int rs2, input int rd, input bit we,
                       input bit ld, input bit mem, input bit br, input bit solo);
    a_rs1 = 5'(rs1); a_rs2 = 5'(rs2); a_rd = 5'(rd); a_we = we;
    a_is_load = ld; a_is_mem = mem; a_is_br = br; a_is_solo = solo;
    a_info = {8{$urandom()}};
  endtask

  task automatic set_b(input int rs1, input int rs2, input int rd, input bit we,
                       input bit ld, input bit mem, input bit br, input bit solo);
    b_rs1 = 5'(rs1); b_rs2 = 5'(rs2); b_rd = 5'(rd); b_we = we;
    b_is_load = ld; b_is_mem = mem; b_is_br = br; b_is_solo = solo;
    b_info = {8{$urandom()}};
  endtask

  function automatic bit uses(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] r);
    return (r != 5'd0) && ((rs1 == r) || (rs2 == r));
  endfunction

  function automatic int model_use();
    if (!rstn || !in_valid[1] || stall || flush_BR) return 0;
    if (m_ld && uses(a_rs1, a_rs2, m_ldrd)) return 0;
    if (!in_valid[0]) return 1;
    if (m_ld && uses(b_rs1, b_rs2, m_ldrd)) return 1;
    if (a_we && uses(b_rs1, b_rs2, a_rd)) return 1;
    if ((a_is_mem && b_is_mem) || a_is_br || a_is_solo || b_is_solo) return 1;
    return 2;
  endfunction

  // Called after inputs settle (just past a negedge); eu is the expected using_num.
  task automatic step(input string tag, input int eu);
    exp_t e;
    #1;
    chk({tag, ".use"}, INFO_W'(using_num), INFO_W'(eu));
    if (!rstn) begin
      m_v = 2'b00; m_ia = '0; m_ib = '0; m_ld = 1'b0; m_ldrd = 5'd0;
      m_dual = 32'd0; m_stall = 32'd0;
    end else if (flush_BR) begin
      m_v = 2'b00; m_ld = 1'b0;
    end else if (stall) begin
      m_stall = m_stall + 32'd1;
    end else begin
      m_v = {eu >= 1, eu == 2};
      if (eu >= 1) m_ia = a_info;
      if (eu == 2) m_ib = b_info;
      if (eu == 2 && b_is_load && b_we && b_rd != 5'd0) begin
        m_ld = 1'b1; m_ldrd = b_rd;
      end else if (eu >= 1 && a_is_load && a_we && a_rd != 5'd0) begin
        m_ld = 1'b1; m_ldrd = a_rd;
      end else begin
        m_ld = 1'b0;
      end
      if (eu == 2) m_dual = m_dual + 32'd1;
    end
    e.v = m_v; e.ia = m_ia; e.ib = m_ib;
    e.chk_a = m_v[1] || !rstn; e.chk_b = m_v[0] || !rstn;
    e.dual = m_dual; e.stl = m_stall;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".exv"}, INFO_W'(ex_valid), INFO_W'(e.v));
    if (e.chk_a) chk({tag, ".infa"}, ex_info_a, e.ia);
    if (e.chk_b) chk({tag, ".infb"}, ex_info_b, e.ib);
    chk({tag, ".dual"}, INFO_W'(dual_cnt), INFO_W'(e.dual));
    chk({tag, ".stl"}, INFO_W'(stall_cnt), INFO_W'(e.stl));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; stall = 1'b0; flush_BR = 1'b0; in_valid = 2'b11;
    set_a(1, 2, 3, 1, 0, 0, 0, 0);
    set_b(5, 6, 4, 1, 0, 0, 0, 0);
    @(negedge clk);
    step("rst0", 0);
    step("rst1", 0);
    rstn = 1'b1;

    // Independent pair dual-issues
    set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(5, 6, 4, 1, 0, 0, 0, 0);
    step("dual", 2);

    // RAW inside the pair: B waits one cycle then issues alone from slot A
    set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(3, 1, 7, 1, 0, 0, 0, 0);
    step("raw0", 1);
    set_a(3, 1, 7, 1, 0, 0, 0, 0); in_valid = 2'b10;
    step("raw1", 1);

    // Load-use: single bubble
    set_a(0, 0, 5, 1, 1, 1, 0, 0);
    step("ld0", 1);
    set_a(5, 1, 6, 1, 0, 0, 0, 0);
    step("ldu0", 0);
    step("ldu1", 1);

    // Stall for three cycles holds EX
    in_valid = 2'b11;
    set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(5, 6, 4, 1, 0, 0, 0, 0);
    step("pre_st", 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(5, 6, 4, 1, 0, 0, 0, 0);
      step("stall", 0);
    end
    stall = 1'b0;

    // Flush with stall and a pending load
    in_valid = 2'b10;
    set_a(0, 0, 9, 1, 1, 1, 0, 0);
    step("ld9", 1);
    flush_BR = 1'b1; stall = 1'b1;
    set_a(9, 2, 1, 1, 0, 0, 0, 0);
    step("flush", 0);
    flush_BR = 1'b0; stall = 1'b0;
    step("postfl", 1);

    // Pairing restrictions
    in_valid = 2'b11;
    set_a(0, 0, 2, 1, 0, 0, 0, 1); set_b(5, 6, 4, 1, 0, 0, 0, 0);
    step("solo_a", 1);
    set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(5, 6, 4, 1, 0, 0, 0, 1);
    step("solo_b", 1);
    set_a(1, 0, 8, 1, 1, 1, 0, 0); set_b(2, 3, 0, 0, 0, 1, 0, 0);
    step("ld_st", 1);
    set_a(1, 2, 0, 0, 0, 0, 1, 0); set_b(5, 6, 4, 1, 0, 0, 0, 0);
    step("br_a", 1);
    set_a(1, 2, 3, 0, 0, 0, 0, 0); set_b(3, 6, 4, 1, 0, 0, 1, 0);
    step("nowe", 2);
    in_valid = 2'b01;
    step("bonly", 0);
    in_valid = 2'b00;
    step("empty", 0);

    // Load in A, dependent B in the following pair only blocks B
    in_valid = 2'b10;
    set_a(0, 0, 10, 1, 1, 1, 0, 0);
    step("ld10", 1);
    in_valid = 2'b11;
    set_a(1, 2, 3, 1, 0, 0, 0, 0); set_b(10, 4, 5, 1, 0, 0, 0, 0);
    step("hazb", 1);

    // Load to x0 creates no hazard
    in_valid = 2'b10;
    set_a(0, 0, 0, 1, 1, 1, 0, 0);
    step("ldx0", 1);
    set_a(0, 0, 1, 1, 0, 0, 0, 0);
    step("x0use", 1);

    // Reset in the middle of a stall discards EX and pending load
    set_a(0, 0, 11, 1, 1, 1, 0, 0);
    step("ld11", 1);
    stall = 1'b1;
    step("st_pre", 0);
    rstn = 1'b0;
    step("rst_st", 0);
    rstn = 1'b1; stall = 1'b0;
    set_a(11, 2, 1, 1, 0, 0, 0, 0);
    step("postrst", 1);

    // Random run against the reference model
    for (int i = 0; i < 400; i++) begin
      rstn     = ($urandom_range(0, 59) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush_BR = ($urandom_range(0, 15) == 0);
      in_valid = 2'($urandom_range(0, 3));
      set_a($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      set_b($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      step("rnd", model_use());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter INFO_W, default 256, width of the opaque per-instruction payload passed to EX.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  2  issue-buffer head validity; bit1 = slot A (oldest), bit0 = slot B.
REQ-005 a_rs1, a_rs2, b_rs1, b_rs2  in  5 each  source register numbers; 0 = none.
REQ-006 a_rd, b_rd  in  5 each  destination registers; a_we, b_we  in  1 each  destination write enables.
REQ-007 a_is_load, b_is_load, a_is_mem, b_is_mem, a_is_br, b_is_br, a_is_solo, b_is_solo  in  1 each  class flags; solo = CSR/priv/div, must issue alone.
REQ-008 a_info, b_info  in  INFO_W each  payload.
REQ-009 flush_BR  in  1  branch-mispredict flush; stall  in  1  DCache or divider stall.
REQ-010 using_num  out  2  instructions consumed from buffer this cycle (0, 1, 2; 3 never driven).
REQ-011 ex_valid  out  2  registered EX-stage validity, bit1 = lane A; ex_info_a, ex_info_b  out  INFO_W  registered payloads.
REQ-012 dual_cnt, stall_cnt  out  32 each  performance counters.

Function
REQ-013 issue_a (combinational) SHALL be 1 iff in_valid[1] & !stall & !flush_BR & !hazA.
REQ-014 hazA SHALL be 1 when ld_pend & a nonzero a_rs1 or a_rs2 equals ld_rd.
REQ-015 issue_b SHALL be 1 iff issue_a & in_valid[0] & !hazB & no pair conflict.
REQ-016 hazB SHALL use REQ-014 rule on b_rs1/b_rs2.
REQ-017 Pair conflict: a_we & a_rd!=0 & a_rd in {b_rs1,b_rs2}; or a_is_mem & b_is_mem; or a_is_br; or a_is_solo; or b_is_solo.
REQ-018 using_num SHALL equal issue_a + issue_b; B never issued without A (in-order).
REQ-019 Load scoreboard: on a cycle with !stall & !flush_BR, ld_pend <= (issued lane is load with we and rd!=0), ld_rd <= that rd; lane B takes priority if both are loads (cannot occur per REQ-017).
REQ-020 On stall (no flush), ld_pend/ld_rd, ex_valid, ex_info_* SHALL hold.
REQ-021 On flush_BR, ld_pend <= 0, ex_valid <= 0; flush dominates stall.
REQ-022 Otherwise ex_valid <= {issue_a, issue_b}; ex_info_a <= a_info when issue_a; ex_info_b <= b_info when issue_b; payload of invalid lane is don't-care.
REQ-023 Latency: instruction visible at buffer head in cycle N appears on ex_valid/ex_info in cycle N+1 if issued.
REQ-024 Load-use: dependent instruction directly after a load SHALL issue one cycle later (single bubble), never earlier.
REQ-025 dual_cnt += 1 each cycle using_num==2; stall_cnt += 1 each cycle stall=1 and flush_BR=0; both wrap modulo 2^32.
REQ-026 in_valid=2'b01 (B without A) SHALL be treated as empty: using_num=0.

Reset
REQ-027 While rstn=0 on a clock edge: ex_valid=0, ld_pend=0, ld_rd=0, ex_info_*=0, dual_cnt=0, stall_cnt=0.
REQ-028 using_num SHALL be 0 in any cycle rstn=0 regardless of inputs.
REQ-029 Reset mid-stall SHALL discard held EX contents; first post-reset cycle behaves as empty pipeline.

Verification
REQ-030 A=add r3,r1,r2; B=add r4,r5,r6; both valid -> using_num=2, next cycle ex_valid=11, dual_cnt=1.
REQ-031 A=add r3,..; B=sub r7,r3,r1 -> using_num=1; next cycle B now at A slot issues, ex_valid=10 twice.
REQ-032 A=ld r5; next cycle A=add r6,r5,r1 -> cycle1 using_num=0, ex_valid=00; cycle2 using_num>=1.
REQ-033 Stall asserted 3 cycles with ex_valid=11 -> using_num=0, ex_valid/ex_info unchanged, stall_cnt=3.
REQ-034 flush_BR together with stall and ld_pend=1 -> using_num=0; next cycle ex_valid=00, ld_pend=0, stall_cnt unchanged.
REQ-035 A=csrrd, B=add -> using_num=1; A=ld, B=st -> using_num=1; in_valid=01 -> using_num=0.
